instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Instruction fetch and sequencing stage of the CPU. Holds the program counter, reads each instruction from synchronous instruction memory and latches it into an instruction register. It presents the `command_group` and `command` fields to the controller for one execute cycle, then selects the next PC from the controller's `branch_select` and the ALU condition.

## Interface
- `PC_WIDTH`, 8, program counter / instruction memory address width (4..16).
- `INSTR_WIDTH`, 16, instruction word width (must be ≥ 6 + PC_WIDTH).
- `clk`  in  1  single system clock, rising edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `start`  in  1  leave IDLE and begin fetching from PC 0.
- `hold`  in  1  freeze sequencing while high.
- `imem_rdata`  in  INSTR_WIDTH  instruction memory read data, valid the cycle after `imem_req`.
- `branch_select`  in  1  from controller, meaningful in EXECUTE only.
- `branch_cond`  in  1  ALU condition result, meaningful in EXECUTE only.
- `imem_addr`  out  PC_WIDTH  instruction memory address, equals `pc`.
- `imem_req`  out  1  read strobe.
- `pc`  out  PC_WIDTH  current program counter.
- `command_group`  out  3  instruction bits [INSTR_WIDTH-1 : INSTR_WIDTH-3] while `instr_valid`, else `NOP group code.
- `command`  out  3  instruction bits [INSTR_WIDTH-4 : INSTR_WIDTH-6] while `instr_valid`, else 3'b000.
- `operand`  out  INSTR_WIDTH-6  remaining low instruction bits, zero when not `instr_valid`.
- `instr_valid`  out  1  high for the EXECUTE cycle of each instruction.
- `retired`  out  16  saturating count of completed instructions.

## Operation
- Four states: IDLE, FETCH, LOAD, EXECUTE.
- IDLE: the block waits here after reset. `start`=1 moves it to FETCH with `pc` = 0. `start` is ignored in every other state.
- FETCH: `imem_req`=1 and `imem_addr`=`pc`. Next state is LOAD unless `hold`=1, in which case the block stays in FETCH and keeps `imem_req` asserted.
- LOAD: the instruction register captures `imem_rdata`, then the block goes to EXECUTE. `hold` is ignored in LOAD because the memory data is valid for only one cycle.
- EXECUTE: `instr_valid`=1 and the instruction fields are decoded from the instruction register.
  - If `hold`=1, the block stays in EXECUTE with outputs stable and takes no PC update.
  - Otherwise, if `branch_select` && `branch_cond`, then `pc` ← `operand[PC_WIDTH-1:0]`. If not, `pc` ← `pc`+1, modulo 2^PC_WIDTH, so the PC wraps from max to 0.
  - On leaving EXECUTE, `retired` increments (saturating at 16'hFFFF) and the next state is FETCH.
- Branch to the same address (self-loop) is legal and refetches that address.
- `branch_select`=1 with `branch_cond`=0 falls through to `pc`+1.
- Reset, including reset during any state, is asynchronous:
  - state = IDLE, `pc` = 0, instruction register = 0.
  - `imem_req` = 0, `instr_valid` = 0, `retired` = 0.
  - `command_group` = `NOP, `command` = 0, `operand` = 0.

## Timing
- Each instruction takes 3 cycles (FETCH, LOAD, EXECUTE) with `hold` low. Every `hold` cycle in FETCH or EXECUTE adds one cycle.
- `start` sampled high in IDLE gives: `imem_req` high in the next cycle, then `instr_valid` high 2 cycles after that.
- `pc` updates on the clock edge that ends EXECUTE. `imem_addr` shows the new `pc` in the FETCH cycle that follows.
- All outputs are registered or decoded directly from registered state. No combinational path runs from `branch_select` or `branch_cond` to any output.
- `branch_select` and `branch_cond` are sampled only on the edge that ends a non-held EXECUTE cycle.

## Test plan
- Reset/idle: assert `reset_n`=0 mid-EXECUTE → all outputs at reset values immediately, state IDLE. Then release with `start`=0 for 10 cycles → `imem_req` stays 0 and `pc`=0.
- Sequential fetch: ROM holds 0x2000, 0x2400, 0x0000; pulse `start`, `branch_select`=0 → `imem_addr` 0,1,2 at 3-cycle spacing; `command_group`=3'b001 and `command`=0 then 1; `retired`=3 after 9 cycles.
- Taken jump: ROM[3]=instruction whose operand low byte is 0x10; `branch_select`=1, `branch_cond`=1 in EXECUTE → next `imem_addr`=0x10. Same instruction with `branch_cond`=0 → next `imem_addr`=4.
- PC wrap: `pc`=0xFF with no branch → next `imem_addr`=0x00, `retired` increments.
- Hold: `hold`=1 for 4 cycles in FETCH → `imem_req` stays high, `imem_addr` stable. `hold`=1 for 2 cycles in EXECUTE → `instr_valid` high for 3 cycles, `retired` increments once, `pc` changes once.
- Saturation: preload near max by running 65,540 instructions → `retired` holds at 0xFFFF.

Source files
------------

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//
// Fetch and sequencing stage of the CPU. Holds the program counter, reads each
// instruction from synchronous instruction memory and latches it into an
// instruction register. The command fields are presented to the controller for
// one EXECUTE cycle, after which the next PC is chosen from branch_select and
// the ALU condition.
//
// Parameters
//   PC_WIDTH       program counter / memory address width (4..16)
//   INSTR_WIDTH    instruction word width (>= 6 + PC_WIDTH)
//   RETIRED_WIDTH  width of the saturating retired counter (1..16); the
//                  counter saturates at all-ones of this width
//   NOP_GROUP      command_group value driven while no instruction is valid
//
// Ports
//   clk            system clock, rising edge
//   reset_n        asynchronous active-low reset
//   start          leave IDLE and begin fetching from PC 0
//   hold           freeze sequencing in FETCH / EXECUTE
//   imem_rdata     memory read data, valid the cycle after imem_req
//   branch_select  controller branch request (EXECUTE only)
//   branch_cond    ALU condition (EXECUTE only)
//   imem_addr      memory address (= pc)
//   imem_req       memory read strobe
//   pc             current program counter
//   command_group  instruction [IW-1:IW-3] while instr_valid, else NOP_GROUP
//   command        instruction [IW-4:IW-6] while instr_valid, else 0
//   operand        instruction [IW-7:0] while instr_valid, else 0
//   instr_valid    high during EXECUTE
//   retired        saturating count of completed instructions
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module instruction_fetch #(
    parameter int          PC_WIDTH      = 8,
    parameter int          INSTR_WIDTH   = 16,
    parameter int          RETIRED_WIDTH = 16,
    parameter logic [2:0]  NOP_GROUP     = 3'b000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   hold,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    input  logic                   branch_select,
    input  logic                   branch_cond,
    output logic [PC_WIDTH-1:0]    imem_addr,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    pc,
    output logic [2:0]             command_group,
    output logic [2:0]             command,
    output logic [INSTR_WIDTH-7:0] operand,
    output logic                   instr_valid,
    output logic [15:0]            retired
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_EXECUTE
    } state_t;

    state_t                   r_state;
    logic [PC_WIDTH-1:0]      r_pc;
    logic [INSTR_WIDTH-1:0]   r_ir;
    logic [RETIRED_WIDTH-1:0] r_retired;
    logic                     r_imem_req;
    logic                     r_instr_valid;

    logic                     w_branch_taken;
    logic [PC_WIDTH-1:0]      w_branch_target;

    assign w_branch_taken  = branch_select && branch_cond;
    assign w_branch_target = r_ir[PC_WIDTH-1:0];

    // Single-process FSM; imem_req and instr_valid are registered alongside the
    // state so they never depend combinationally on any input.
    // NOTE: every register here is assigned with <= so all updates see the
    // pre-edge values; blocking assignments would make the result depend on
    // statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_pc          <= '0;
            r_ir          <= '0;
            r_retired     <= '0;
            r_imem_req    <= 1'b0;
            r_instr_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_FETCH;
                        r_pc       <= '0;
                        r_imem_req <= 1'b1;
                    end
                end

                // Request stays asserted while held so the memory keeps
                // returning data for the current PC.
                S_FETCH: begin
                    if (!hold) begin
                        r_state    <= S_LOAD;
                        r_imem_req <= 1'b0;
                    end
                end

                // Memory data is valid for this cycle only, so hold is
                // deliberately not consulted here.
                S_LOAD: begin
                    r_ir          <= imem_rdata;
                    r_state       <= S_EXECUTE;
                    r_instr_valid <= 1'b1;
                end

                S_EXECUTE: begin
                    if (!hold) begin
                        if (w_branch_taken) begin
                            r_pc <= w_branch_target;
                        end else begin
                            r_pc <= r_pc + PC_WIDTH'(1);   // wraps modulo 2^PC_WIDTH
                        end
                        if (r_retired != '1) begin
                            r_retired <= r_retired + RETIRED_WIDTH'(1);
                        end
                        r_state       <= S_FETCH;
                        r_instr_valid <= 1'b0;
                        r_imem_req    <= 1'b1;
                    end
                end

                default: begin
                    r_state       <= S_IDLE;
                    r_imem_req    <= 1'b0;
                    r_instr_valid <= 1'b0;
                end
            endcase
        end
    end

    // Field decode straight from the instruction register, gated by the
    // registered valid flag.
    assign imem_req      = r_imem_req;
    assign instr_valid   = r_instr_valid;
    assign pc            = r_pc;
    assign imem_addr     = r_pc;
    assign command_group = r_instr_valid ? r_ir[INSTR_WIDTH-1 -: 3] : NOP_GROUP;
    assign command       = r_instr_valid ? r_ir[INSTR_WIDTH-4 -: 3] : 3'b000;
    assign operand       = r_instr_valid ? r_ir[INSTR_WIDTH-7:0]    : '0;
    assign retired       = 16'(r_retired);

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
//
// Directed bench for instruction_fetch. A small synchronous ROM model feeds the
// main instance (default parameters). A second instance with a 4-bit retired
// counter and a 4-bit PC exercises counter saturation and PC wrap within a
// short run.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_instruction_fetch;

    localparam int PW = 8;
    localparam int IW = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic          hold;
    logic          branch_select;
    logic          branch_cond;
    logic [IW-1:0] imem_rdata;

    logic [PW-1:0] imem_addr;
    logic          imem_req;
    logic [PW-1:0] pc;
    logic [2:0]    command_group;
    logic [2:0]    command;
    logic [IW-7:0] operand;
    logic          instr_valid;
    logic [15:0]   retired;

    // Saturation instance signals
    logic [9:0]    s_rdata;
    logic [3:0]    s_imem_addr;
    logic          s_imem_req;
    logic [3:0]    s_pc;
    logic [2:0]    s_command_group;
    logic [2:0]    s_command;
    logic [3:0]    s_operand;
    logic          s_instr_valid;
    logic [15:0]   s_retired;

    logic [IW-1:0] rom [256];

    int n_checks = 0;
    int n_fail   = 0;

    instruction_fetch #(.PC_WIDTH(PW), .INSTR_WIDTH(IW)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .hold          (hold),
        .imem_rdata    (imem_rdata),
        .branch_select (branch_select),
        .branch_cond   (branch_cond),
        .imem_addr     (imem_addr),
        .imem_req      (imem_req),
        .pc            (pc),
        .command_group (command_group),
        .command       (command),
        .operand       (operand),
        .instr_valid   (instr_valid),
        .retired       (retired)
    );

    instruction_fetch #(.PC_WIDTH(4), .INSTR_WIDTH(10), .RETIRED_WIDTH(4)) dut_sat (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .hold          (1'b0),
        .imem_rdata    (s_rdata),
        .branch_select (1'b0),
        .branch_cond   (1'b0),
        .imem_addr     (s_imem_addr),
        .imem_req      (s_imem_req),
        .pc            (s_pc),
        .command_group (s_command_group),
        .command       (s_command),
        .operand       (s_operand),
        .instr_valid   (s_instr_valid),
        .retired       (s_retired)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory: data appears the cycle after the request.
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= rom[imem_addr];
    end

    assign s_rdata = '0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // From a FETCH cycle, advance through LOAD into EXECUTE.
    task automatic to_execute();
        step();
        step();
    endtask

    // Drive branch inputs for the closing edge of EXECUTE, then clear them.
    task automatic finish_exec(input logic bs, input logic bc);
        branch_select = bs;
        branch_cond   = bc;
        step();
        branch_select = 1'b0;
        branch_cond   = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},   32'(imem_req),      32'h0);
        check({tag, "_valid"}, 32'(instr_valid),   32'h0);
        check({tag, "_pc"},    32'(pc),            32'h0);
        check({tag, "_addr"},  32'(imem_addr),     32'h0);
        check({tag, "_grp"},   32'(command_group), 32'h0);
        check({tag, "_cmd"},   32'(command),       32'h0);
        check({tag, "_opnd"},  32'(operand),       32'h0);
        check({tag, "_ret"},   32'(retired),       32'h0);
    endtask

    initial begin
        reset_n       = 1'b0;
        start         = 1'b0;
        hold          = 1'b0;
        branch_select = 1'b0;
        branch_cond   = 1'b0;
        foreach (rom[i]) rom[i] = '0;
        rom[0]    = 16'h2000;   // group 1, cmd 0
        rom[1]    = 16'h2400;   // group 1, cmd 1
        rom[2]    = 16'h0000;
        rom[3]    = 16'h4010;   // group 2, operand 0x010
        rom[8'h11] = 16'h4003;  // jump back to 3
        rom[4]    = 16'h4004;   // self-loop target
        rom[5]    = 16'h40FF;   // jump to 0xFF

        // ---- reset state ----
        #12;
        check_reset_outputs("rst");
        check("rst_sat_req",   32'(s_imem_req),      32'h0);
        check("rst_sat_valid", 32'(s_instr_valid),   32'h0);
        check("rst_sat_ret",   32'(s_retired),       32'h0);
        check("rst_sat_fields", 32'({s_command_group, s_command, s_operand, s_imem_addr, s_pc}), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        check("idle_req", 32'(imem_req), 32'h0);

        // ---- sequential fetch ----
        start = 1'b1;
        step();
        start = 1'b0;
        check("seq0_req",  32'(imem_req),  32'h1);
        check("seq0_addr", 32'(imem_addr), 32'h0);
        step();
        check("seq0_load_req",   32'(imem_req),    32'h0);
        check("seq0_load_valid", 32'(instr_valid), 32'h0);
        step();
        check("seq0_valid", 32'(instr_valid),   32'h1);
        check("seq0_grp",   32'(command_group), 32'h1);
        check("seq0_cmd",   32'(command),       32'h0);
        finish_exec(1'b0, 1'b0);
        check("seq1_addr",  32'(imem_addr),   32'h1);
        check("seq1_ret",   32'(retired),     32'h1);
        check("seq1_valid", 32'(instr_valid), 32'h0);
        to_execute();
        check("seq1_grp", 32'(command_group), 32'h1);
        check("seq1_cmd", 32'(command),       32'h1);
        finish_exec(1'b0, 1'b0);
        check("seq2_addr", 32'(imem_addr), 32'h2);
        to_execute();
        check("seq2_valid", 32'(instr_valid), 32'h1);
        finish_exec(1'b0, 1'b0);
        check("seq3_addr", 32'(imem_addr), 32'h3);
        check("seq3_ret",  32'(retired),   32'h3);

        // ---- taken / not-taken branches ----
        to_execute();
        check("jmp_grp",  32'(command_group), 32'h2);
        check("jmp_opnd", 32'(operand),       32'h010);
        finish_exec(1'b1, 1'b1);
        check("jmp_taken_addr", 32'(imem_addr), 32'h10);
        check("jmp_taken_ret",  32'(retired),   32'h4);
        to_execute();
        finish_exec(1'b0, 1'b0);
        check("jmp_seq_addr", 32'(imem_addr), 32'h11);
        to_execute();
        finish_exec(1'b1, 1'b1);
        check("jmp_back_addr", 32'(imem_addr), 32'h3);
        to_execute();
        finish_exec(1'b1, 1'b0);
        check("jmp_nt_addr", 32'(imem_addr), 32'h4);
        check("jmp_nt_ret",  32'(retired),   32'h7);
        to_execute();
        finish_exec(1'b1, 1'b1);
        check("selfloop_addr", 32'(imem_addr), 32'h4);
        check("selfloop_ret",  32'(retired),   32'h8);
        to_execute();
        finish_exec(1'b0, 1'b1);
        check("cond_only_addr", 32'(imem_addr), 32'h5);

        // ---- PC wrap ----
        to_execute();
        finish_exec(1'b1, 1'b1);
        check("to_ff_addr", 32'(imem_addr), 32'hFF);
        check("to_ff_ret",  32'(retired),   32'd10);
        to_execute();
        finish_exec(1'b0, 1'b0);
        check("wrap_addr", 32'(imem_addr), 32'h00);
        check("wrap_pc",   32'(pc),        32'h00);
        check("wrap_ret",  32'(retired),   32'd11);

        // ---- hold in FETCH ----
        hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("hold_f_req",   32'(imem_req),    32'h1);
            check("hold_f_addr",  32'(imem_addr),   32'h0);
            check("hold_f_valid", 32'(instr_valid), 32'h0);
        end
        hold = 1'b0;
        step();
        check("hold_f_load_req", 32'(imem_req), 32'h0);
        step();
        check("hold_f_exec_valid", 32'(instr_valid),   32'h1);
        check("hold_f_exec_grp",   32'(command_group), 32'h1);

        // ---- hold in EXECUTE: branch inputs must be ignored while held ----
        hold          = 1'b1;
        branch_select = 1'b1;
        branch_cond   = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check("hold_e_valid", 32'(instr_valid),   32'h1);
            check("hold_e_grp",   32'(command_group), 32'h1);
            check("hold_e_pc",    32'(pc),            32'h0);
            check("hold_e_ret",   32'(retired),       32'd11);
        end
        hold          = 1'b0;
        branch_select = 1'b0;
        branch_cond   = 1'b0;
        step();
        check("hold_e_done_valid", 32'(instr_valid), 32'h0);
        check("hold_e_done_pc",    32'(pc),          32'h1);
        check("hold_e_done_ret",   32'(retired),     32'd12);

        // ---- asynchronous reset in EXECUTE ----
        to_execute();
        check("pre_rst_valid", 32'(instr_valid), 32'h1);
        #3;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("idle10_req", 32'(imem_req), 32'h0);
            check("idle10_pc",  32'(pc),       32'h0);
        end

        // ---- retired saturation (4-bit counter instance) ----
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (14 * 3) step();
        check("sat14_ret", 32'(s_retired), 32'd14);
        repeat (3) step();
        check("sat15_ret",  32'(s_retired), 32'd15);
        check("main15_ret", 32'(retired),   32'd15);
        repeat (5 * 3) step();
        check("sat_hold_ret", 32'(s_retired),   32'd15);
        check("sat_pc_wrap",  32'(s_pc),        32'd4);
        check("main20_ret",   32'(retired),     32'd20);
        check("main20_addr",  32'(imem_addr),   32'd20);
        check("sat_req",      32'(s_imem_req),  32'h1);
        check("sat_addr",     32'(s_imem_addr), 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
